// File: rtl/pos_encoder.sv
// Debounced 16-button position encoder: synchronizes raw buttons, accepts a
// stable one-hot press as a 4-bit index and holds it until acknowledged.
module pos_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] btn,
  input  logic        ack,
  output logic [3:0]  pos,
  output logic        valid,
  output logic        multi_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HOLD,
    RELEASE
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  logic [15:0] btn_s1;
  logic [15:0] btn_s2;
  logic [15:0] snap;
  logic [15:0] cnt;

  // Highest set bit wins; only ever called on a one-hot value.
  function automatic logic [3:0] encode(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign busy = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; the async reset branch covers every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      btn_s1    <= '0;
      btn_s2    <= '0;
      snap      <= '0;
      cnt       <= '0;
      pos       <= '0;
      valid     <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      btn_s1    <= btn;
      btn_s2    <= btn_s1;
      multi_err <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s2 != '0) begin
            snap  <= btn_s2;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (btn_s2 == '0) begin
            state <= IDLE;
          end else if (btn_s2 != snap) begin
            snap <= btn_s2;
            cnt  <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 16'd1;
          end else if ($onehot(snap)) begin
            pos   <= encode(snap);
            valid <= 1'b1;
            state <= HOLD;
          end else begin
            multi_err <= 1'b1;
            cnt       <= '0;
            state     <= RELEASE;
          end
        end
        HOLD: begin
          // Buttons are ignored here; only the consumer ends the selection.
          if (ack) begin
            valid <= 1'b0;
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (btn_s2 != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_encoder.sv
// Directed bench for pos_encoder: default debounce instance plus a
// DEBOUNCE_CYCLES=1 instance for the minimum-latency case.
module tb_pos_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] btn, btn1;
  logic        ack, ack1;
  logic [3:0]  pos, pos1;
  logic        valid, valid1;
  logic        multi_err, multi_err1;
  logic        busy, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pos_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn(btn), .ack(ack),
    .pos(pos), .valid(valid), .multi_err(multi_err), .busy(busy)
  );

  pos_encoder #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .btn(btn1), .ack(ack1),
    .pos(pos1), .valid(valid1), .multi_err(multi_err1), .busy(busy1)
  );

  // Advance n rising edges, leaving time 1 ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_to_idle(input string name);
    int n;
    ack = 1'b0;
    btn = '0;
    n = 0;
    while (busy && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%0b, expected 0 within 50 cycles", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = '0; btn1 = '0; ack = 1'b0; ack1 = 1'b0;
    #3;
    checks++;
    if ({pos, valid, multi_err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset: pos=%0d valid=%0b multi_err=%0b busy=%0b, expected all 0",
               pos, valid, multi_err, busy);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
    checks++;
    if ({valid, busy, valid1, busy1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: valid=%0b busy=%0b valid1=%0b busy1=%0b, expected 0",
               valid, busy, valid1, busy1);
    end
  endtask

  task automatic test_single_press();
    int vcount;
    btn = 16'h0010;
    tick(6);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: valid=%0b at edge 6, expected 0", valid);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || pos !== 4'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: valid=%0b pos=%0d busy=%0b, expected 1/4/1", valid, pos, busy);
    end
    btn = 16'h0800;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (valid !== 1'b1 || pos !== 4'd4) begin
        errors++;
        $display("FAIL hold_ignore: valid=%0b pos=%0d, expected 1/4", valid, pos);
      end
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || pos !== 4'd4) begin
      errors++;
      $display("FAIL single_ack: valid=%0b pos=%0d, expected 0/4", valid, pos);
    end
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (valid) vcount++;
    end
    checks++;
    if (vcount !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_held: valid cycles=%0d busy=%0b, expected 0/1", vcount, busy);
    end
    btn = '0;
    tick(5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL release_early: busy=%0b at zero edge 5, expected 1", busy);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0 || pos !== 4'd4) begin
      errors++;
      $display("FAIL release_idle: busy=%0b pos=%0d, expected 0/4", busy, pos);
    end
  endtask

  task automatic test_bounce();
    int vcount;
    vcount = 0;
    for (int p = 0; p < 5; p++) begin
      btn = (p % 2 == 1) ? 16'h0100 : 16'h0000;
      for (int c = 0; c < 2; c++) begin
        tick(1);
        if (valid) vcount++;
      end
    end
    btn = 16'h0100;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      if (valid) vcount++;
    end
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL bounce_quiet: valid cycles=%0d, expected 0", vcount);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || pos !== 4'd8) begin
      errors++;
      $display("FAIL bounce_accept: valid=%0b pos=%0d, expected 1/8", valid, pos);
    end
    ack = 1'b1;
    tick(1);
    release_to_idle("bounce_release");
  endtask

  task automatic test_multi();
    btn = 16'h0081;
    tick(6);
    checks++;
    if (multi_err !== 1'b0) begin
      errors++;
      $display("FAIL multi_early: multi_err=%0b, expected 0", multi_err);
    end
    tick(1);
    checks++;
    if (multi_err !== 1'b1 || valid !== 1'b0 || pos !== 4'd8) begin
      errors++;
      $display("FAIL multi_pulse: multi_err=%0b valid=%0b pos=%0d, expected 1/0/8",
               multi_err, valid, pos);
    end
    tick(1);
    checks++;
    if (multi_err !== 1'b0 || valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL multi_single: multi_err=%0b valid=%0b busy=%0b, expected 0/0/1",
               multi_err, valid, busy);
    end
    release_to_idle("multi_release");
    btn = 16'h8000;
    tick(7);
    checks++;
    if (valid !== 1'b1 || pos !== 4'd15) begin
      errors++;
      $display("FAIL multi_next: valid=%0b pos=%0d, expected 1/15", valid, pos);
    end
    ack = 1'b1;
    tick(1);
    release_to_idle("multi_next_release");
  endtask

  task automatic test_glide();
    int bad;
    bad = 0;
    btn = 16'h0002;
    tick(2);
    btn = 16'h0004;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      if (valid) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL glide_early: early valid cycles=%0d, expected 0", bad);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || pos !== 4'd2) begin
      errors++;
      $display("FAIL glide_accept: valid=%0b pos=%0d, expected 1/2", valid, pos);
    end
    ack = 1'b1;
    tick(1);
    release_to_idle("glide_release");
  endtask

  task automatic test_reset_mid();
    btn = 16'h0200;
    tick(7);
    checks++;
    if (valid !== 1'b1 || pos !== 4'd9) begin
      errors++;
      $display("FAIL rstmid_accept: valid=%0b pos=%0d, expected 1/9", valid, pos);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || pos !== 4'd0 || busy !== 1'b0 || multi_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%0b pos=%0d busy=%0b multi_err=%0b, expected all 0",
               valid, pos, busy, multi_err);
    end
    #2 rst = 1'b0;
    tick(6);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_early: valid=%0b at edge 6, expected 0", valid);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || pos !== 4'd9) begin
      errors++;
      $display("FAIL rstmid_repress: valid=%0b pos=%0d, expected 1/9", valid, pos);
    end
    ack = 1'b1;
    tick(1);
    release_to_idle("rstmid_release");
  endtask

  task automatic test_ack_held();
    int vcount;
    ack = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    btn = 16'h0020;
    tick(6);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ackheld_debounce: valid=%0b busy=%0b, expected 0/1", valid, busy);
    end
    tick(1);
    checks++;
    if (valid !== 1'b1 || pos !== 4'd5) begin
      errors++;
      $display("FAIL ackheld_accept: valid=%0b pos=%0d, expected 1/5", valid, pos);
    end
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (valid) vcount++;
    end
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL ackheld_pulse: extra valid cycles=%0d, expected 0", vcount);
    end
    btn = 16'h0000;
    tick(12);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ackheld_idle: busy=%0b, expected 0", busy);
    end
    btn = 16'h0040;
    vcount = 0;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (valid) begin
        vcount++;
        checks++;
        if (pos !== 4'd6) begin
          errors++;
          $display("FAIL ackheld_pos: pos=%0d, expected 6", pos);
        end
      end
    end
    checks++;
    if (vcount !== 1) begin
      errors++;
      $display("FAIL ackheld_second: valid cycles=%0d, expected 1", vcount);
    end
    release_to_idle("ackheld_release");
  endtask

  task automatic test_debounce_one();
    btn1 = 16'h0008;
    tick(3);
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL d1_early: valid=%0b at edge 3, expected 0", valid1);
    end
    tick(1);
    checks++;
    if (valid1 !== 1'b1 || pos1 !== 4'd3) begin
      errors++;
      $display("FAIL d1_accept: valid=%0b pos=%0d, expected 1/3", valid1, pos1);
    end
    ack1 = 1'b1;
    tick(1);
    ack1 = 1'b0;
    btn1 = '0;
    checks++;
    if (valid1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL d1_ack: valid=%0b busy=%0b, expected 0/1", valid1, busy1);
    end
    tick(2);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL d1_release_early: busy=%0b, expected 1", busy1);
    end
    tick(1);
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL d1_release: busy=%0b, expected 0", busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_glide();
    test_reset_mid();
    test_ack_held();
    test_debounce_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
